// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-boundary definitions: per-boundary bundle widths, control-bit
// positions and the entry-occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IFID_DATA_W  = 64;   // pc + instr
  localparam int unsigned IDEX_CTRL_W  = 6;
  localparam int unsigned IDEX_DATA_W  = 101;  // rd1 + rd2 + imm + rd
  localparam int unsigned EXMEM_CTRL_W = 6;
  localparam int unsigned EXMEM_DATA_W = 69;   // alu/imm + rd2 + rd
  localparam int unsigned MEMWB_CTRL_W = 2;
  localparam int unsigned MEMWB_DATA_W = 69;   // mem data + alu + rd

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_ZERO     = 5;

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } skid_state_e;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID,
    MAIN_CLEAR
  } main_sel_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush-to-bubble,
// optional two-entry skid buffer and saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  main_sel_e         main_sel;
  logic              skid_load, skid_clr;
  logic              in_fire, out_fire;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // SKID=0 never reaches ST_TWO: ONE with in & !out is blocked by in_ready.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = (state_q != ST_TWO) & ~rst & ~flush;
  end else begin : g_comb_ready
    assign in_ready = ((state_q == ST_EMPTY) | out_ready) & ~rst & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_TWO;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_sel  = MAIN_HOLD;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_sel = MAIN_CLEAR;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) main_sel = MAIN_LOAD_IN;
        ST_ONE: begin
          if (in_fire && out_fire) main_sel = MAIN_LOAD_IN;
          else if (in_fire)        skid_load = 1'b1;
          else if (out_fire)       main_sel = MAIN_CLEAR;
        end
        ST_TWO: begin
          if (out_fire) begin
            main_sel = MAIN_LOAD_SKID;
            skid_clr = 1'b1;
          end
        end
        default: begin
          main_sel = MAIN_CLEAR;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Bundles are zeroed whenever their entry is empty, so outputs need no valid gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      case (main_sel)
        MAIN_LOAD_IN: begin
          main_ctrl_q <= in_ctrl;
          main_data_q <= in_data;
        end
        MAIN_LOAD_SKID: begin
          main_ctrl_q <= skid_ctrl_q;
          main_data_q <= skid_data_q;
        end
        MAIN_CLEAR: begin
          main_ctrl_q <= '0;
          main_data_q <= '0;
        end
        default: ;
      endcase
      if (skid_clr) begin
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else if (skid_load) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (out_valid & ~out_ready),
    .value(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1, SKID=0 and a 4-bit-counter variant share one
// stimulus stream; a FIFO-occupancy model predicts every output each cycle.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 6;
  localparam int unsigned DW = 69;
  localparam int unsigned BW = CW + DW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          s_ir, s_ov, n_ir, n_ov, t_ir, t_ov;
  logic [CW-1:0] s_oc, n_oc, t_oc;
  logic [DW-1:0] s_od, n_od, t_od;
  logic [15:0]   s_sc, n_sc;
  logic [3:0]    t_sc;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready),
    .out_ctrl(s_oc), .out_data(s_od), .stall_cnt(s_sc));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(n_ov), .out_ready(out_ready),
    .out_ctrl(n_oc), .out_data(n_od), .stall_cnt(n_sc));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(t_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(t_ov), .out_ready(out_ready),
    .out_ctrl(t_oc), .out_data(t_od), .stall_cnt(t_sc));

  // Reference: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
  logic [BW-1:0] q_s[$];
  logic [BW-1:0] q_n[$];
  int unsigned   sc_s, sc_n, sc_t;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    logic          r, f, iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          x_ir, x_ov;
    logic [DW-1:0] x_od;
    logic [15:0]   x_sc;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, f, iv, input logic [CW-1:0] ic,
                              input logic [DW-1:0] id, input logic ordy, x_ir, x_ov,
                              input logic [DW-1:0] x_od, input logic [15:0] x_sc);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
    v.x_ir = x_ir; v.x_ov = x_ov; v.x_od = x_od; v.x_sc = x_sc;
    return v;
  endfunction

  function automatic int unsigned inc_sat(input int unsigned v, input int unsigned w);
    return (v < ((32'd1 << w) - 1)) ? v + 1 : v;
  endfunction

  function automatic logic m_ir(input int unsigned sz, input bit skid);
    if (rst || flush) return 1'b0;
    if (skid) return sz < 2;
    return (sz == 0) || out_ready;
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
  endtask

  task automatic step();
    logic          ir_s, ir_n;
    logic [BW-1:0] fs, fn;
    #1;
    ir_s = m_ir(q_s.size(), 1'b1);
    ir_n = m_ir(q_n.size(), 1'b0);
    chk("skid.in_ready",   BW'(s_ir), BW'(ir_s));
    chk("sat.in_ready",    BW'(t_ir), BW'(ir_s));
    chk("noskid.in_ready", BW'(n_ir), BW'(ir_n));
    @(posedge clk);
    if (rst) begin
      q_s.delete(); q_n.delete();
      sc_s = 0; sc_n = 0; sc_t = 0;
    end else begin
      if (q_s.size() > 0 && !out_ready) begin
        sc_s = inc_sat(sc_s, 16);
        sc_t = inc_sat(sc_t, 4);
      end
      if (q_n.size() > 0 && !out_ready) sc_n = inc_sat(sc_n, 16);
      if (flush) begin
        q_s.delete(); q_n.delete();
      end else begin
        if (q_s.size() > 0 && out_ready) void'(q_s.pop_front());
        if (in_valid && ir_s) q_s.push_back({in_ctrl, in_data});
        if (q_n.size() > 0 && out_ready) void'(q_n.pop_front());
        if (in_valid && ir_n) q_n.push_back({in_ctrl, in_data});
      end
    end
    #1;
    fs = (q_s.size() > 0) ? q_s[0] : '0;
    fn = (q_n.size() > 0) ? q_n[0] : '0;
    chk("skid.out_valid",   BW'(s_ov), BW'(q_s.size() > 0));
    chk("skid.out_ctrl",    BW'(s_oc), BW'(fs[BW-1:DW]));
    chk("skid.out_data",    BW'(s_od), BW'(fs[DW-1:0]));
    chk("skid.stall_cnt",   BW'(s_sc), BW'(sc_s));
    chk("sat.out_valid",    BW'(t_ov), BW'(q_s.size() > 0));
    chk("sat.out_data",     BW'(t_od), BW'(fs[DW-1:0]));
    chk("sat.stall_cnt",    BW'(t_sc), BW'(sc_t));
    chk("noskid.out_valid", BW'(n_ov), BW'(q_n.size() > 0));
    chk("noskid.out_ctrl",  BW'(n_oc), BW'(fn[BW-1:DW]));
    chk("noskid.out_data",  BW'(n_od), BW'(fn[DW-1:0]));
    chk("noskid.stall_cnt", BW'(n_sc), BW'(sc_n));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 6'h3F, 69'd5, 1'b1);
    sc_s = 0; sc_n = 0; sc_t = 0;

    // Reset, streaming 1..8, then A/B/C under backpressure (3 stalled cycles).
    tbl[0] = mk(1, 0, 1, 6'h3F, 69'd5, 1, 0, 0, 69'd0, 16'd0);
    tbl[1] = mk(1, 0, 1, 6'h3F, 69'd5, 1, 0, 0, 69'd0, 16'd0);
    tbl[2] = mk(0, 0, 0, 6'h00, 69'd0, 1, 1, 0, 69'd0, 16'd0);
    for (int i = 1; i <= 8; i++)
      tbl[2+i] = mk(0, 0, 1, CW'(i), DW'(i), 1, 1, 1, DW'(i), 16'd0);
    tbl[11] = mk(0, 0, 0, 6'h00, 69'd0,   1, 1, 0, 69'd0,   16'd0);
    tbl[12] = mk(0, 0, 1, 6'h0A, 69'h0A,  0, 1, 1, 69'h0A,  16'd0);
    tbl[13] = mk(0, 0, 1, 6'h0B, 69'h0B,  0, 1, 1, 69'h0A,  16'd1);
    tbl[14] = mk(0, 0, 1, 6'h0C, 69'h0C,  0, 0, 1, 69'h0A,  16'd2);
    tbl[15] = mk(0, 0, 1, 6'h0C, 69'h0C,  0, 0, 1, 69'h0A,  16'd3);
    tbl[16] = mk(0, 0, 1, 6'h0C, 69'h0C,  1, 0, 1, 69'h0B,  16'd3);
    tbl[17] = mk(0, 0, 1, 6'h0C, 69'h0C,  1, 1, 1, 69'h0C,  16'd3);
    tbl[18] = mk(0, 0, 0, 6'h00, 69'd0,   1, 1, 0, 69'd0,   16'd3);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy);
      #1;
      chk("tbl.in_ready", BW'(s_ir), BW'(tbl[i].x_ir));
      step();
      chk("tbl.out_valid", BW'(s_ov), BW'(tbl[i].x_ov));
      chk("tbl.out_data",  BW'(s_od), BW'(tbl[i].x_od));
      chk("tbl.stall_cnt", BW'(s_sc), BW'(tbl[i].x_sc));
      if (!tbl[i].x_ov) chk("tbl.out_ctrl_zero", BW'(s_oc), BW'(0));
    end

    // Flush while holding two beats, with a new beat offered the same cycle.
    drive(0, 0, 1, 6'h21, 69'h1AA, 0); step();
    drive(0, 0, 1, 6'h22, 69'h1BB, 0); step();
    drive(0, 1, 1, 6'h23, 69'h1CC, 1);
    #1;
    chk("flush.in_ready", BW'(s_ir), BW'(0));
    step();
    chk("flush.out_valid", BW'(s_ov), BW'(0));
    chk("flush.out_ctrl",  BW'(s_oc), BW'(0));
    chk("flush.stall_cnt", BW'(s_sc), BW'(16'd4));
    drive(0, 0, 0, 6'h00, 69'd0, 1);
    repeat (2) begin
      step();
      chk("flush.bubble", BW'(s_ov), BW'(0));
    end
    drive(0, 0, 1, 6'h24, 69'h1DD, 1); step();
    chk("flush.next_beat", BW'(s_od), BW'(69'h1DD));
    drive(0, 0, 0, 6'h00, 69'd0, 1); step();

    // SKID=0: one beat per cycle, then a single-cycle stall.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, CW'(k), DW'(32'h100 + k), 1);
      #1;
      chk("noskid.stream_ready", BW'(n_ir), BW'(1));
      step();
      chk("noskid.stream_data", BW'(n_od), BW'(32'h100 + k));
    end
    drive(0, 0, 1, 6'h05, 69'h105, 0);
    #1;
    chk("noskid.stall_ready", BW'(n_ir), BW'(0));
    step();
    chk("noskid.stall_hold", BW'(n_od), BW'(69'h104));
    drive(0, 0, 1, 6'h05, 69'h105, 1);
    #1;
    chk("noskid.resume_ready", BW'(n_ir), BW'(1));
    step();
    chk("noskid.resume_data", BW'(n_od), BW'(69'h105));
    drive(0, 0, 0, 6'h00, 69'd0, 1); step();

    // Saturation of the 4-bit counter over 20 stalled cycles.
    drive(1, 0, 0, 6'h00, 69'd0, 1); step();
    drive(0, 0, 1, 6'h15, 69'h55, 0); step();
    drive(0, 0, 0, 6'h00, 69'd0, 0);
    repeat (20) step();
    chk("sat.stall_cnt_15", BW'(t_sc), BW'(4'd15));
    chk("skid.stall_cnt_20", BW'(s_sc), BW'(16'd20));

    // Random traffic with varying backpressure density.
    for (int i = 0; i < 3000; i++) begin
      int unsigned rdy_pct;
      rdy_pct = (i / 500) % 2 == 0 ? 80 : 30;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 99) < 70, CW'($urandom),
            {DW'($urandom), 32'($urandom), 5'($urandom)},
            $urandom_range(0, 99) < rdy_pct);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
